// File: rtl/axi_pkg.sv
// Shared AXI response codes, burst encoding and the slave's read/write FSM state encodings.
// Also holds the response-selection rule used by both channels.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Decode error wins over a burst request; bursts are answered as one beat.
    function automatic logic [1:0] resp_code(input logic in_range, input logic [7:0] len);
        if (!in_range)
            return RESP_DECERR;
        if (len != 8'd0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-wide SRAM: combinational read port, clocked write port with per-byte enables.
// Contents are deliberately not reset.
module axi_sram_mem
    import axi_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_dat,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_dat,
    input  logic [3:0]                     wr_be
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rd_dat = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI SRAM slave: R beat RD_LAT+1 cycles after AR, B response WR_LAT+1 cycles after AW+W.
// One transaction per direction; R/B are held until rready/bready, new requests stall until then.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_slave_awvalid,
    output logic        io_slave_awready,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    input  logic        io_slave_wvalid,
    output logic        io_slave_wready,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    output logic        io_slave_bvalid,
    input  logic        io_slave_bready,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    input  logic        io_slave_arvalid,
    output logic        io_slave_arready,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    output logic        io_slave_rvalid,
    input  logic        io_slave_rready,
    output logic [31:0] io_slave_rdata,
    output logic [1:0]  io_slave_rresp,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both bounds.
    function automatic logic hit(input logic [31:0] off);
        return {1'b0, off} < SPAN;
    endfunction

    r_state_t    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q;
    logic [31:0] ar_addr_q, ar_off, rdata_q, mem_rd_dat;
    logic [3:0]  ar_id_q;
    logic [7:0]  ar_len_q;
    logic [1:0]  rresp_q;
    logic        r_start, r_fetch;

    w_state_t    w_state_q, w_state_d;
    logic [3:0]  w_cnt_q;
    logic [31:0] aw_addr_q, aw_off, wdata_q;
    logic [3:0]  aw_id_q, wstrb_q;
    logic [7:0]  aw_len_q;
    logic [1:0]  bresp_q, wr_resp;
    logic        aw_done_q, w_done_q, aw_hs, w_hs, w_start, w_commit, mem_we;

    logic        unused_ok;
    assign unused_ok = ^{io_slave_awsize, io_slave_arsize, io_slave_awburst ^ BURST_INCR,
                         io_slave_arburst, io_slave_wlast};

    assign ar_off  = ar_addr_q - BASE_ADDR;
    assign aw_off  = aw_addr_q - BASE_ADDR;
    assign wr_resp = resp_code(hit(aw_off), aw_len_q);
    assign mem_we  = w_commit && (wr_resp == RESP_OKAY);

    axi_sram_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clock  (clock),
        .rd_idx (ar_off[IW+1:2]),
        .rd_dat (mem_rd_dat),
        .wr_en  (mem_we),
        .wr_idx (aw_off[IW+1:2]),
        .wr_dat (wdata_q),
        .wr_be  (wstrb_q)
    );

    // ---------------- read channel ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state_q <= R_IDLE;
        else       r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_start   = 1'b0;
        r_fetch   = 1'b0;
        case (r_state_q)
            R_IDLE: if (io_slave_arvalid) begin
                r_start   = 1'b1;
                r_state_d = R_WAIT;
            end
            R_WAIT: if (r_cnt_q == 4'd0) begin
                r_fetch   = 1'b1;
                r_state_d = R_RESP;
            end
            R_RESP: if (io_slave_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // A write committing on the fetch edge is not yet visible, so the read sees old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt_q   <= 4'd0;
            ar_addr_q <= 32'd0;
            ar_id_q   <= 4'd0;
            ar_len_q  <= 8'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else if (r_start) begin
            r_cnt_q   <= 4'(RD_LAT);
            ar_addr_q <= io_slave_araddr;
            ar_id_q   <= io_slave_arid;
            ar_len_q  <= io_slave_arlen;
        end else if (r_fetch) begin
            rdata_q <= hit(ar_off) ? mem_rd_dat : 32'd0;
            rresp_q <= resp_code(hit(ar_off), ar_len_q);
        end else if (r_state_q == R_WAIT) begin
            r_cnt_q <= r_cnt_q - 4'd1;
        end
    end

    assign io_slave_arready = (r_state_q == R_IDLE) && !reset;
    assign io_slave_rvalid  = (r_state_q == R_RESP);
    assign io_slave_rlast   = (r_state_q == R_RESP);
    assign io_slave_rid     = ar_id_q;
    assign io_slave_rdata   = rdata_q;
    assign io_slave_rresp   = rresp_q;

    // ---------------- write channel ----------------
    assign io_slave_awready = (w_state_q == W_IDLE) && !aw_done_q && !reset;
    assign io_slave_wready  = (w_state_q == W_IDLE) && !w_done_q && !reset;
    assign aw_hs = io_slave_awvalid && io_slave_awready;
    assign w_hs  = io_slave_wvalid && io_slave_wready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) w_state_q <= W_IDLE;
        else       w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        w_start   = 1'b0;
        w_commit  = 1'b0;
        case (w_state_q)
            W_IDLE: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                w_start   = 1'b1;
                w_state_d = W_WAIT;
            end
            W_WAIT: if (w_cnt_q == 4'd0) begin
                w_commit  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: if (io_slave_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_cnt_q   <= 4'd0;
            aw_addr_q <= 32'd0;
            aw_id_q   <= 4'd0;
            aw_len_q  <= 8'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= io_slave_awaddr;
                aw_id_q   <= io_slave_awid;
                aw_len_q  <= io_slave_awlen;
            end
            if (w_hs) begin
                wdata_q <= io_slave_wdata;
                wstrb_q <= io_slave_wstrb;
            end
            if (w_start) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                w_cnt_q   <= 4'(WR_LAT);
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (w_commit)
                bresp_q <= wr_resp;
            else if (w_state_q == W_WAIT)
                w_cnt_q <= w_cnt_q - 4'd1;
        end
    end

    assign io_slave_bvalid = (w_state_q == W_RESP);
    assign io_slave_bid    = aw_id_q;
    assign io_slave_bresp  = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-level memory and response model.
module tb_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          RLAT  = 2;

    logic        clock = 1'b0, reset = 1'b1;
    logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0, rlast;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [3:0]  awid = 0, wstrb = 0, bid, arid = 0, rid;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 0, arsize = 0;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;

    int checks = 0, passed = 0;
    logic [31:0] ref_mem [int];

    always #5 clock = ~clock;

    axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
        .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
        .io_slave_awburst(awburst),
        .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata),
        .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
        .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp),
        .io_slave_bid(bid),
        .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
        .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
        .io_slave_arburst(arburst),
        .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rdata(rdata),
        .io_slave_rresp(rresp), .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] len);
        longint unsigned lo = BASE;
        longint unsigned hi = longint'(BASE) + 4 * DEPTH;
        if (a < lo || a >= hi) return 2'b11;
        if (len != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (exp_resp(a, 8'd0) == 2'b11) return 32'd0;
        return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [7:0] len);
        logic [31:0] w;
        if (exp_resp(a, len) != 2'b00) return;
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[widx(a)] = w;
    endtask

    // ---------------- bus drivers ----------------
    // order: 0 = AW one cycle before W, 1 = W one cycle before AW, 2 = same cycle
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [3:0] id, input logic [7:0] len, input int order,
                             output logic [1:0] resp, output logic [3:0] bid_o, output bit tmo);
        bit awd = 0, wd = 0, aw_hs, w_hs;
        int c = 0;
        tmo = 0; resp = 2'b01; bid_o = ~id;
        awaddr = a; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b01;
        wdata = d; wstrb = s; wlast = 1'b1;
        while (!(awd && wd) && c < 50) begin
            awvalid = !awd && (order != 1 || c >= 1);
            wvalid  = !wd && (order != 0 || c >= 1);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clock); #1;
            awd |= aw_hs; wd |= w_hs; c++;
        end
        awvalid = 0; wvalid = 0;
        c = 0;
        while (!bvalid && c < 50) begin @(posedge clock); #1; c++; end
        if (!bvalid) begin tmo = 1; return; end
        resp = bresp; bid_o = bid;
        bready = 1; @(posedge clock); #1; bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input int delay, input int hold,
                            output logic [31:0] d, output logic [1:0] resp, output logic [3:0] rid_o,
                            output logic last_o, output int lat, output bit stable, output bit tmo);
        int c = 0;
        tmo = 0; stable = 1; lat = 0; d = 0; resp = 0; rid_o = 0; last_o = 0;
        repeat (delay) begin @(posedge clock); #1; end
        araddr = a; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        while (!arready && c < 50) begin @(posedge clock); #1; c++; end
        if (!arready) begin arvalid = 0; tmo = 1; return; end
        @(posedge clock); #1; arvalid = 0;
        do begin @(posedge clock); #1; lat++; end while (!rvalid && lat < 50);
        if (!rvalid) begin tmo = 1; return; end
        d = rdata; resp = rresp; rid_o = rid; last_o = rlast;
        repeat (hold) begin
            @(posedge clock); #1;
            if (rvalid !== 1'b1 || rdata !== d || rid !== rid_o || rresp !== resp || rlast !== 1'b1)
                stable = 0;
        end
        rready = 1; @(posedge clock); #1; rready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clock); #1;
        checks++; if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'd0)
            $display("FAIL reset_ctrl: got %b expected 000000", {awready, wready, arready, bvalid, rvalid, rlast}); else passed++;
        checks++; if ({rdata, rresp, rid, bresp, bid} !== 44'd0)
            $display("FAIL reset_data: got %h expected 0", {rdata, rresp, rid, bresp, bid}); else passed++;
        reset = 0; #1;
        checks++; if ({awready, wready, arready} !== 3'b111)
            $display("FAIL reset_release_rdy: got %b expected 111", {awready, wready, arready}); else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l; int lat; bit st, to;
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3, 8'd0, 0, r, i, to);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 8'd0);
        checks++; if (to || r !== 2'b00 || i !== 4'h3)
            $display("FAIL basic_bresp: got to=%0d resp=%b id=%h expected resp=00 id=3", to, r, i); else passed++;
        axi_read(32'h8000_0010, 4'h7, 8'd0, 0, 0, d, r, i, l, lat, st, to);
        checks++; if (to || d !== 32'hDEAD_BEEF || r !== 2'b00)
            $display("FAIL basic_rdata: got %h resp %b expected deadbeef resp 00", d, r); else passed++;
        checks++; if (lat !== RLAT + 1)
            $display("FAIL basic_rd_latency: got %0d expected %0d", lat, RLAT + 1); else passed++;
        checks++; if (i !== 4'h7 || l !== 1'b1)
            $display("FAIL basic_rid_rlast: got id=%h last=%b expected id=7 last=1", i, l); else passed++;
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l; int lat; bit st, to;
        axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 4'h1, 8'd0, 1, r, i, to);
        model_write(32'h8000_0020, 32'h1122_3344, 4'hF, 8'd0);
        axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 4'h2, 8'd0, 2, r, i, to);
        model_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 8'd0);
        checks++; if (to || r !== 2'b00 || i !== 4'h2)
            $display("FAIL strobe_bresp: got resp=%b id=%h expected 00 id=2", r, i); else passed++;
        axi_read(32'h8000_0020, 4'h4, 8'd0, 0, 0, d, r, i, l, lat, st, to);
        checks++; if (to || d !== 32'h11BB_33DD)
            $display("FAIL strobe_merge: got %h expected 11bb33dd", d); else passed++;
    endtask

    task automatic test_decode();
        logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l; int lat; bit st, to;
        axi_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 4'h0, 8'd0, 2, r, i, to);
        model_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 8'd0);
        axi_read(32'h7FFF_FFFC, 4'h6, 8'd0, 0, 0, d, r, i, l, lat, st, to);
        checks++; if (to || r !== 2'b11 || d !== 32'd0)
            $display("FAIL decode_read: got resp=%b data=%h expected 11 / 0", r, d); else passed++;
        axi_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 4'h8, 8'd0, 0, r, i, to);
        checks++; if (to || r !== 2'b11 || i !== 4'h8)
            $display("FAIL decode_write: got resp=%b id=%h expected 11 id=8", r, i); else passed++;
        axi_read(32'h8000_0000, 4'h6, 8'd0, 0, 0, d, r, i, l, lat, st, to);
        checks++; if (to || d !== exp_rdata(32'h8000_0000))
            $display("FAIL decode_unchanged: got %h expected %h", d, exp_rdata(32'h8000_0000)); else passed++;
    endtask

    task automatic test_burst_hold();
        logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l; int lat; bit st, to;
        axi_read(32'h8000_0000, 4'h5, 8'd3, 0, 4, d, r, i, l, lat, st, to);
        checks++; if (to || r !== 2'b10 || l !== 1'b1 || i !== 4'h5)
            $display("FAIL burst_resp: got resp=%b last=%b id=%h expected 10 1 5", r, l, i); else passed++;
        checks++; if (d !== exp_rdata(32'h8000_0000))
            $display("FAIL burst_rdata: got %h expected %h", d, exp_rdata(32'h8000_0000)); else passed++;
        checks++; if (st !== 1'b1)
            $display("FAIL burst_hold_stable: got %0d expected 1", st); else passed++;
    endtask

    task automatic test_reset_abort();
        logic [1:0] r; logic [3:0] i; logic [31:0] d; logic l; int lat, c; bit st, to, seen;
        axi_write(32'h8000_0040, 32'h1234_5678, 4'hF, 4'h1, 8'd0, 2, r, i, to);
        model_write(32'h8000_0040, 32'h1234_5678, 4'hF, 8'd0);
        awaddr = 32'h8000_0040; awid = 4'h2; awlen = 0; wdata = 32'h0000_00FF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; c = 0;
        while (!(awready && wready) && c < 50) begin @(posedge clock); #1; c++; end
        @(posedge clock); #1;
        awvalid = 0; wvalid = 0; reset = 1; #1;
        checks++; if ({awready, wready, arready, bvalid} !== 4'd0)
            $display("FAIL abort_rdy_in_reset: got %b expected 0000", {awready, wready, arready, bvalid}); else passed++;
        repeat (3) @(posedge clock); #1;
        reset = 0;
        seen = 0;
        repeat (10) begin @(posedge clock); #1; if (bvalid) seen = 1; end
        checks++; if (seen !== 1'b0)
            $display("FAIL abort_no_bvalid: got %0d expected 0", seen); else passed++;
        axi_read(32'h8000_0040, 4'h3, 8'd0, 0, 0, d, r, i, l, lat, st, to);
        checks++; if (to || d !== 32'h1234_5678)
            $display("FAIL abort_old_word: got %h expected 12345678", d); else passed++;
    endtask

    task automatic test_concurrent();
        logic [1:0] wr_r, rd_r; logic [3:0] wr_i, rd_i; logic [31:0] d, va, vb; logic l;
        int lat; bit st, to_w, to_r;
        va = $urandom; vb = $urandom;
        fork
            axi_write(32'h8000_0080, va, 4'hF, 4'h9, 8'd0, 2, wr_r, wr_i, to_w);
            axi_read(32'h8000_0010, 4'hA, 8'd0, 0, 0, d, rd_r, rd_i, l, lat, st, to_r);
        join
        model_write(32'h8000_0080, va, 4'hF, 8'd0);
        checks++; if (to_w || wr_r !== 2'b00 || wr_i !== 4'h9)
            $display("FAIL conc_write: got resp=%b id=%h expected 00 id=9", wr_r, wr_i); else passed++;
        checks++; if (to_r || d !== exp_rdata(32'h8000_0010) || rd_i !== 4'hA)
            $display("FAIL conc_read: got %h id=%h expected %h id=a", d, rd_i, exp_rdata(32'h8000_0010)); else passed++;
        // Read issued a cycle before a split AW/W write: fetch and commit share an edge.
        fork
            axi_write(32'h8000_0080, vb, 4'hF, 4'hB, 8'd0, 0, wr_r, wr_i, to_w);
            axi_read(32'h8000_0080, 4'hC, 8'd0, 0, 0, d, rd_r, rd_i, l, lat, st, to_r);
        join
        checks++; if (to_r || d !== va || rd_i !== 4'hC)
            $display("FAIL collide_old_data: got %h id=%h expected %h id=c", d, rd_i, va); else passed++;
        model_write(32'h8000_0080, vb, 4'hF, 8'd0);
        axi_read(32'h8000_0080, 4'hD, 8'd0, 0, 0, d, rd_r, rd_i, l, lat, st, to_r);
        checks++; if (to_r || d !== vb)
            $display("FAIL collide_new_data: got %h expected %h", d, vb); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] r; logic [3:0] i, id, s; logic [31:0] a, d, v; logic [7:0] len; logic l;
        int lat; bit st, to;
        for (int k = 0; k < 16; k++) begin
            a = 32'h8000_0100 + 32'(4 * k); v = $urandom;
            axi_write(a, v, 4'hF, 4'(k), 8'd0, $urandom_range(0, 2), r, i, to);
            model_write(a, v, 4'hF, 8'd0);
        end
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: a = BASE - 32'(4 * $urandom_range(1, 64));
                1: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
                default: a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom; s = 4'($urandom);
                axi_write(a, v, s, id, len, $urandom_range(0, 2), r, i, to);
                checks++; if (to || r !== exp_resp(a, len) || i !== id)
                    $display("FAIL rand_write: addr=%h got resp=%b id=%h expected %b id=%h", a, r, i, exp_resp(a, len), id); else passed++;
                model_write(a, v, s, len);
            end else begin
                axi_read(a, id, len, 0, $urandom_range(0, 2), d, r, i, l, lat, st, to);
                checks++; if (to || r !== exp_resp(a, len) || d !== exp_rdata(a) || i !== id || lat !== RLAT + 1)
                    $display("FAIL rand_read: addr=%h got %h/%b id=%h lat=%0d expected %h/%b id=%h lat=%0d",
                             a, d, r, i, lat, exp_rdata(a), exp_resp(a, len), id, RLAT + 1); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_decode();
        test_burst_hold();
        test_reset_abort();
        test_concurrent();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two.
REQ-003 SHALL have parameter RD_LAT, default 2: extra wait cycles before a read beat is presented; range 0..15.
REQ-004 SHALL have parameter WR_LAT, default 1: extra wait cycles before a write response is presented; range 0..15.
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have the AW channel, one port each:
- io_slave_awvalid in 1, io_slave_awready out 1
- io_slave_awaddr in 32, io_slave_awid in 4, io_slave_awlen in 8
- io_slave_awsize in 3, io_slave_awburst in 2
REQ-008 SHALL have the W channel, one port each: io_slave_wvalid in 1, io_slave_wready out 1, io_slave_wdata in 32, io_slave_wstrb in 4, io_slave_wlast in 1.
REQ-009 SHALL have the B channel, one port each: io_slave_bvalid out 1, io_slave_bready in 1, io_slave_bresp out 2, io_slave_bid out 4.
REQ-010 SHALL have the AR channel, one port each:
- io_slave_arvalid in 1, io_slave_arready out 1
- io_slave_araddr in 32, io_slave_arid in 4, io_slave_arlen in 8
- io_slave_arsize in 3, io_slave_arburst in 2
REQ-011 SHALL have the R channel, one port each: io_slave_rvalid out 1, io_slave_rready in 1, io_slave_rdata out 32, io_slave_rresp out 2, io_slave_rlast out 1, io_slave_rid out 4.

Function
REQ-012 Read FSM SHALL have states R_IDLE, R_WAIT and R_RESP.
- io_slave_arready = 1 only in R_IDLE.
- An AR handshake captures araddr, arid and arlen, then goes to R_WAIT with the counter set to RD_LAT.
REQ-013 R_WAIT SHALL decrement the counter each cycle and go to R_RESP when it is 0; rvalid rises exactly RD_LAT+1 cycles after the AR handshake.
REQ-014 R_RESP SHALL hold rvalid=1, rlast=1, rid=captured arid and stable rdata/rresp until rready=1, then return to R_IDLE the next cycle; back-to-back reads are allowed.
REQ-015 Write FSM SHALL have states W_IDLE, W_WAIT and W_RESP.
- In W_IDLE, awready and wready are each 1 until their own handshake has occurred.
- AW and W are accepted in either order or in the same cycle.
REQ-016 Once both the AW and the W handshake have completed, the write FSM SHALL load the counter with WR_LAT and enter W_WAIT; on expiry it commits the write and enters W_RESP.
REQ-017 W_RESP SHALL hold bvalid=1 and bid=captured awid until bready=1, then return to W_IDLE.
REQ-018 The word index SHALL be (addr - BASE_ADDR)>>2.
- addr[1:0] and size are ignored.
- rdata is always the full aligned word; lane extraction belongs to the master.
REQ-019 Writes SHALL update only the byte lanes whose wstrb bit is 1; wstrb=0 commits nothing but still returns OKAY.
REQ-020 An address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL give resp 2'b11 (DECERR): reads return rdata=0, writes are dropped.
REQ-021 An in-range access with len!=0 SHALL be treated as a single beat: rlast=1, resp 2'b10 (SLVERR), the read returns the addressed word and the write is dropped; the burst type is ignored.
REQ-022 Otherwise resp SHALL be 2'b00 (OKAY).
REQ-023 The read array access SHALL occur on the R_WAIT-to-R_RESP transition; if a write commits to the same word in that cycle, the read returns the pre-write data.
REQ-024 Read and write FSMs SHALL operate concurrently and independently, with one outstanding transaction per direction.

Reset
REQ-025 While reset=1, all outputs SHALL be 0, including the readies; after release, awready=wready=arready=1 and both FSMs are in IDLE.
REQ-026 Reset asserted mid-transaction SHALL abort it with no response; a write not yet committed is not committed; array contents are not reset.

Structure
REQ-027 Package axi_pkg SHALL hold the resp codes (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11), BURST_INCR 2'b01 and the R/W state encodings.
REQ-028 Storage SHALL live in sub-module axi_sram_mem: DEPTH_WORDS x 32 array, one asynchronous read port, one synchronous write port with 4-bit byte enable.

Verification
REQ-029 Write 0x8000_0010 data 0xDEADBEEF strb 4'hF (AW one cycle before W), then read the same address -> bresp 0, rdata 0xDEADBEEF, rvalid exactly 3 cycles after the AR handshake at RD_LAT=2.
REQ-030 Write 0x1122_3344 with strb 4'hF, then 0xAABB_CCDD with strb 4'b0101 to the same word, W before AW in the first case and same-cycle in the second -> read 0x11BB_33DD.
REQ-031 Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH 1024) -> rresp 2'b11, rdata 0; bresp 2'b11; array unchanged.
REQ-032 arlen=3 read at 0x8000_0000 -> a single beat with rlast=1 and rresp 2'b10; rready held 0 for 4 cycles -> rvalid, rdata, rid=4'h5 held stable throughout.
REQ-033 Reset asserted during W_WAIT of a write of 0x0000_00FF -> no bvalid; a later read returns the old word; all readies are 0 during reset.
REQ-034 Concurrent read and write to different words in the same cycle -> both complete with correct ids and data; same-word collision returns the old data per REQ-023.
